// File: rtl/regfile_arbiter_pkg.sv
// Shared types and constants for the two-requester RegFile arbiter.
// The FSM state enum, the requester ids and the address range helper live here.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Entries at or above DEPTH do not exist in the RegFile behind the arbiter.
  function automatic logic addrInRange(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Bundle of requester, response and RegFile-side signals for regfile_arbiter.
// The master modport is the requesters plus the RegFile; the slave modport is the arbiter.
interface regfile_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 3
);

  logic             Req0;
  logic             Req1;
  logic             Wr0;
  logic             Wr1;
  logic [ADDR-1:0]  Addr0;
  logic [ADDR-1:0]  Addr1;
  logic [WIDTH-1:0] WData0;
  logic [WIDTH-1:0] WData1;
  logic             Ack0;
  logic             Ack1;
  logic [WIDTH-1:0] RData0;
  logic [WIDTH-1:0] RData1;
  logic             Busy;
  logic             RF_WrEn;
  logic             RF_RdEn;
  logic [ADDR-1:0]  RF_Address;
  logic [WIDTH-1:0] RF_WrData;
  logic [WIDTH-1:0] RF_RdData;

  modport master (
    output Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, RF_RdData,
    input  Ack0, Ack1, RData0, RData1, Busy, RF_WrEn, RF_RdEn, RF_Address, RF_WrData
  );

  modport slave (
    input  Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, RF_RdData,
    output Ack0, Ack1, RData0, RData1, Busy, RF_WrEn, RF_RdEn, RF_Address, RF_WrData
  );

endinterface

// File: rtl/regfile_arbiter_rr_picker.sv
// Grant selection between two level requests.
// Round-robin by default; REGFILE_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module rr_picker (
  input  logic [1:0] req,
  input  logic       lastOwner,
  output logic       grant
);
  import regfile_arb_pkg::*;

  // A lone request always wins; only ties depend on the configured policy.
  always_comb begin
    grant = REQ0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    if (!req[0] && req[1]) grant = REQ1;
`else
    if (req[0] && req[1]) grant = (lastOwner == REQ0) ? REQ1 : REQ0;
    else if (req[1])      grant = REQ1;
`endif
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbiter and sequencer sharing one single-port RegFile between two requesters.
// Optional build macro: REGFILE_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module regfile_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR  = 3
) (
  input logic             CLK,
  input logic             RST,
  regfile_arbiter_if.slave bus
);
  import regfile_arb_pkg::*;

  state_t           state;
  state_t           nextState;
  logic             lastOwner;
  logic             owner;
  logic             grant;
  logic             anyReq;
  logic             cmdWr;
  logic             cmdInRange;
  logic             winWr;
  logic [ADDR-1:0]  winAddr;
  logic [WIDTH-1:0] winData;
  logic             winInRange;
  logic             wrEnNext;
  logic             rdEnNext;
  logic             ackPulse;
  logic             ack0Next;
  logic             ack1Next;
  logic             captureRd;

  rr_picker uPicker (
    .req       ({bus.Req1, bus.Req0}),
    .lastOwner (lastOwner),
    .grant     (grant)
  );

  assign anyReq     = bus.Req0 | bus.Req1;
  assign winWr      = (grant == REQ1) ? bus.Wr1    : bus.Wr0;
  assign winAddr    = (grant == REQ1) ? bus.Addr1  : bus.Addr0;
  assign winData    = (grant == REQ1) ? bus.WData1 : bus.WData0;
  assign winInRange = addrInRange(int'(winAddr), DEPTH);

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (anyReq) nextState = ST_ISSUE;
      ST_ISSUE:  nextState = cmdWr ? ST_RESP : ST_RDWAIT;
      ST_RDWAIT: nextState = ST_RESP;
      ST_RESP:   nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  // Outputs are registered, so these are the values they take at the next edge:
  // the RF enable is decided at grant time so it is visible throughout ISSUE.
  always_comb begin
    wrEnNext  = 1'b0;
    rdEnNext  = 1'b0;
    captureRd = (state == ST_RDWAIT);
    ackPulse  = ((state == ST_ISSUE) && cmdWr) || (state == ST_RDWAIT);
    if ((state == ST_IDLE) && anyReq && winInRange) begin
      wrEnNext = winWr;
      rdEnNext = !winWr;
    end
    ack0Next = ackPulse && (owner == REQ0);
    ack1Next = ackPulse && (owner == REQ1);
  end

  // RF_Address and RF_WrData double as the latched command for the whole transaction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lastOwner      <= REQ1;
      owner          <= REQ0;
      cmdWr          <= 1'b0;
      cmdInRange     <= 1'b0;
      bus.RF_WrEn    <= 1'b0;
      bus.RF_RdEn    <= 1'b0;
      bus.RF_Address <= '0;
      bus.RF_WrData  <= '0;
      bus.Ack0       <= 1'b0;
      bus.Ack1       <= 1'b0;
      bus.RData0     <= '0;
      bus.RData1     <= '0;
      bus.Busy       <= 1'b0;
    end else begin
      bus.RF_WrEn <= wrEnNext;
      bus.RF_RdEn <= rdEnNext;
      bus.Ack0    <= ack0Next;
      bus.Ack1    <= ack1Next;
      bus.Busy    <= (nextState != ST_IDLE);
      if ((state == ST_IDLE) && anyReq) begin
        owner          <= grant;
        lastOwner      <= grant;
        cmdWr          <= winWr;
        cmdInRange     <= winInRange;
        bus.RF_Address <= winAddr;
        bus.RF_WrData  <= winData;
      end
      if (captureRd) begin
        if (owner == REQ0) bus.RData0 <= cmdInRange ? bus.RF_RdData : '0;
        else               bus.RData1 <= cmdInRange ? bus.RF_RdData : '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural RegFile (DEPTH=6).
// Directed vector table, tie / reset sequences, then randomized traffic against a reference model.
module tb_regfile_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 6;
  localparam int ADDR  = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  regfile_arbiter_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  regfile_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural RegFile: registered read data, one cycle of latency.
  logic [WIDTH-1:0] rfMem [0:7];
  always @(posedge CLK) begin
    if (bus.RF_WrEn) rfMem[bus.RF_Address] <= bus.RF_WrData;
    if (bus.RF_RdEn) bus.RF_RdData <= rfMem[bus.RF_Address];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int who;
    bit wr;
    int addr;
    int data;
    int expRData;
    int expSpacing;
  } vec_t;

  vec_t vecs[14];

  int checkCount = 0;
  int passCount  = 0;
  int lastGrant  = 1;
  logic [WIDTH-1:0] expRD [2];
  logic [WIDTH-1:0] modelMem [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input int who, input bit wr, input int addr, input int data);
    if (who == 0) begin
      bus.Req0 = 1'b1; bus.Wr0 = wr; bus.Addr0 = addr[2:0]; bus.WData0 = data[15:0];
    end else begin
      bus.Req1 = 1'b1; bus.Wr1 = wr; bus.Addr1 = addr[2:0]; bus.WData1 = data[15:0];
    end
  endtask

  task automatic dropReq(input int who);
    if (who == 0) bus.Req0 = 1'b0;
    else          bus.Req1 = 1'b0;
  endtask

  // Reference policy: lone request wins; ties go to the requester not granted last.
  function automatic int pickWinner(input bit p0, input bit p1);
    if (p0 && p1) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (lastGrant == 1) ? 0 : 1;
`endif
    end
    return p0 ? 0 : 1;
  endfunction

  // Called with requests already driven while the DUT is in IDLE; returns in the next IDLE cycle.
  task automatic checkOutput(input int expWho, input bit expWr, input int expAddr,
                             input int expData, input int expRData, output int ackCyc);
    int cnt = 0;
    int enSeen = 0;
    bit gotAck = 1'b0;
    bit inRange = (expAddr < DEPTH);
    int expLat = expWr ? 2 : 3;
    ackCyc = cyc;
    while (!gotAck && cnt < 8) begin
      @(posedge CLK); #1;
      cnt++;
      if (bus.RF_WrEn || bus.RF_RdEn) begin
        enSeen++;
        check("en_cycle", 32'(cnt), 32'd1);
        check("en_kind", 32'({bus.RF_WrEn, bus.RF_RdEn}), expWr ? 32'd2 : 32'd1);
        check("rf_addr", 32'(bus.RF_Address), 32'(expAddr));
        if (expWr) check("rf_wdata", 32'(bus.RF_WrData), 32'(expData[15:0]));
      end
      if (bus.Ack0 || bus.Ack1) begin
        gotAck = 1'b1;
        ackCyc = cyc;
      end
    end
    check("ack_seen", 32'(gotAck), 32'd1);
    check("ack_owner", 32'({bus.Ack1, bus.Ack0}), (expWho == 1) ? 32'd2 : 32'd1);
    check("ack_latency", 32'(cnt), 32'(expLat));
    check("en_count", 32'(enSeen), inRange ? 32'd1 : 32'd0);
    check("busy_at_ack", 32'(bus.Busy), 32'd1);
    if (!expWr) expRD[expWho] = expRData[15:0];
    check("rdata0", 32'(bus.RData0), 32'(expRD[0]));
    check("rdata1", 32'(bus.RData1), 32'(expRD[1]));
    @(posedge CLK); #1;
    check("ack_one_cycle", 32'({bus.Ack1, bus.Ack0}), 32'd0);
    check("busy_idle", 32'(bus.Busy), 32'd0);
    check("rdata_hold", (expWho == 0) ? 32'(bus.RData0) : 32'(bus.RData1), 32'(expRD[expWho]));
    lastGrant = expWho;
    if (expWr && inRange) modelMem[expAddr] = expData[15:0];
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_wren"},  32'(bus.RF_WrEn), 32'd0);
    check({tag, "_rden"},  32'(bus.RF_RdEn), 32'd0);
    check({tag, "_addr"},  32'(bus.RF_Address), 32'd0);
    check({tag, "_wdata"}, 32'(bus.RF_WrData), 32'd0);
    check({tag, "_acks"},  32'({bus.Ack1, bus.Ack0}), 32'd0);
    check({tag, "_rd0"},   32'(bus.RData0), 32'd0);
    check({tag, "_rd1"},   32'(bus.RData1), 32'd0);
    check({tag, "_busy"},  32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackCyc;
    int prevAck;
    int expWho;
    bit pend [2];
    bit cw [2];
    int ca [2];
    int cd [2];

    bus.Req0 = 1'b0; bus.Wr0 = 1'b0; bus.Addr0 = '0; bus.WData0 = '0;
    bus.Req1 = 1'b0; bus.Wr1 = 1'b0; bus.Addr1 = '0; bus.WData1 = '0;
    expRD[0] = '0;
    expRD[1] = '0;
    for (int i = 0; i < 8; i++) modelMem[i] = '0;

    vecs[0]  = '{0, 1'b1, 2, 'h000B, 0, 0};
    vecs[1]  = '{1, 1'b0, 2, 0, 'h000B, 4};
    vecs[2]  = '{0, 1'b1, 6, 'hBEEF, 0, 3};
    vecs[3]  = '{1, 1'b0, 7, 0, 0, 4};
    vecs[4]  = '{0, 1'b1, 0, 'h000E, 0, 3};
    vecs[5]  = '{0, 1'b1, 1, 'h000D, 0, 3};
    vecs[6]  = '{0, 1'b1, 2, 'h000B, 0, 3};
    vecs[7]  = '{0, 1'b1, 3, 'h0007, 0, 3};
    vecs[8]  = '{0, 1'b0, 0, 0, 'h000E, 4};
    vecs[9]  = '{0, 1'b0, 1, 0, 'h000D, 4};
    vecs[10] = '{0, 1'b0, 2, 0, 'h000B, 4};
    vecs[11] = '{0, 1'b0, 3, 0, 'h0007, 4};
    vecs[12] = '{1, 1'b1, 4, 'h1234, 0, 3};
    vecs[13] = '{1, 1'b1, 5, 'h5678, 0, 3};

    repeat (3) @(posedge CLK);
    #1;
    checkResetValues("reset");
    RST = 1'b0;

    prevAck = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].data);
      checkOutput(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].expRData, ackCyc);
      dropReq(vecs[i].who);
      if (vecs[i].expSpacing != 0) check("ack_spacing", 32'(ackCyc - prevAck), 32'(vecs[i].expSpacing));
      prevAck = ackCyc;
    end

    // Both requesters held high with writes: grants alternate (or stay on 0 with fixed priority).
    applyStimulus(0, 1'b1, 1, 'h00A1);
    applyStimulus(1, 1'b1, 3, 'h00B3);
    for (int i = 0; i < 4; i++) begin
      expWho = pickWinner(1'b1, 1'b1);
      checkOutput(expWho, 1'b1, (expWho == 0) ? 1 : 3, (expWho == 0) ? 'h00A1 : 'h00B3, 0, ackCyc);
    end
    dropReq(0);
    dropReq(1);

    // Reset asserted while a read sits in RDWAIT: no Ack, everything back to reset values.
    applyStimulus(0, 1'b0, 1, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    dropReq(0);
    @(posedge CLK); #1;
    checkResetValues("midreset");
    RST = 1'b0;
    expRD[0] = '0;
    expRD[1] = '0;
    lastGrant = 1;
    @(posedge CLK); #1;
    check("midreset_no_ack", 32'({bus.Ack1, bus.Ack0}), 32'd0);
    applyStimulus(0, 1'b0, 1, 0);
    checkOutput(0, 1'b0, 1, 0, 32'(modelMem[1]), ackCyc);
    dropReq(0);

    // Randomized traffic: losers keep their request and command stable until served.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int r = 0; r < 80; r++) begin
      for (int w = 0; w < 2; w++) begin
        if (!pend[w] && ($urandom_range(0, 1) == 1 || (w == 1 && !pend[0]))) begin
          pend[w] = 1'b1;
          cw[w]   = 1'($urandom_range(0, 1));
          ca[w]   = int'($urandom_range(0, 7));
          cd[w]   = int'($urandom_range(0, 65535));
          applyStimulus(w, cw[w], ca[w], cd[w]);
        end
      end
      expWho = pickWinner(pend[0], pend[1]);
      checkOutput(expWho, cw[expWho], ca[expWho], cd[expWho],
                  (ca[expWho] < DEPTH) ? 32'(modelMem[ca[expWho]]) : 0, ackCyc);
      pend[expWho] = 1'b0;
      dropReq(expWho);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and sequencer for the single-port RegFile, sharing one WrEn/RdEn/Address/WrData port between two independent masters. It accepts level-sensitive requests, picks a winner (round-robin by default), drives one RegFile access, and returns a one-cycle Ack with read data to the winner. It sits directly in front of the RegFile instance; the RegFile reads with one cycle of latency: RdData is registered, and valid the cycle after RdEn is sampled.

## Interface
- WIDTH, 16, data width; matches RegFile WIDTH
- DEPTH, 8, number of RegFile entries
- ADDR, 3, address width; DEPTH <= 2**ADDR
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset; one clock; reset is synchronous and active-high
- Req0 / Req1  in  1  request, level; held until Ack
- Wr0 / Wr1  in  1  1 = write, 0 = read; stable while Req high
- Addr0 / Addr1  in  ADDR  target entry
- WData0 / WData1  in  WIDTH  write data
- Ack0 / Ack1  out  1  one-cycle completion pulse
- RData0 / RData1  out  WIDTH  read data; valid while Ack high, held afterwards
- Busy  out  1  high in every state except IDLE
- RF_WrEn / RF_RdEn  out  1  RegFile enables
- RF_Address  out  ADDR  RegFile address
- RF_WrData  out  WIDTH  RegFile write data
- RF_RdData  in  WIDTH  RegFile read data

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE:
  - If any Req is high, latch the winner's Wr/Addr/WData and the owner id, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Drive RF_WrEn (write) or RF_RdEn (read) high for exactly one cycle, with RF_Address and RF_WrData from the latched command.
  - Next state is RESP for a write, RDWAIT for a read.
- RDWAIT: capture RF_RdData into the owner's RData register, then go to RESP.
- RESP: pulse Ack of the owner only, then go to IDLE.
- Arbitration:
  - A lone request wins.
  - If both Req0 and Req1 are high, grant the requester not granted last.
  - last_owner resets to 1, so requester 0 wins the first tie.
  - last_owner updates on every grant.
- Requests are levels. A Req still high in the IDLE cycle after RESP counts as a new transaction. Requesters deassert Req in the cycle after Ack.
- Req changes outside IDLE are ignored. The command is latched and never re-sampled mid-transaction.
- Out-of-range access (Addr >= DEPTH):
  - No RF enable is driven in ISSUE.
  - A write is dropped; a read returns 0.
  - Ack still pulses with normal latency.
- All outputs are registered.
- Non-owner RData holds its previous value.

## Timing
- Reset values: RF_WrEn=0, RF_RdEn=0, RF_Address=0, RF_WrData=0, Ack0=Ack1=0, RData0=RData1=0, Busy=0, state=IDLE, last_owner=1.
- RST high at any edge forces reset values at that edge. Any in-flight transaction is discarded with no Ack and no further RF enable.
- Write latency: Req sampled at edge N (in IDLE) -> RF_WrEn high in cycle N+1 -> Ack high in cycle N+2.
- Read latency: Req sampled at edge N -> RF_RdEn high in cycle N+1 -> RDWAIT in cycle N+2 -> Ack and RData valid in cycle N+3.
- Throughput, back-to-back with the IDLE arbitration cycle:
  - writes: one every 3 cycles
  - reads: one every 4 cycles
- RF enables are never high together, and each is never high outside ISSUE.

## Configuration
- REGFILE_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins ties; last_owner is not used, and requester 1 can starve.
- REGFILE_ARB_FIXED_PRIO_EN undefined (default): round-robin as in Operation.

## Structure
- Package regfile_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_RDWAIT, ST_RESP
  - requester id constants REQ0=0, REQ1=1
- Natural sub-module: rr_picker. It takes req[1:0] and last_owner and returns a grant id; the REGFILE_ARB_FIXED_PRIO_EN switch lives inside it.
- The top level holds the FSM, the command latch, and the output registers.

## Test plan
- Reset then single write: Req0, Wr0=1, Addr0=2, WData0=0x000B -> RF_WrEn high for one cycle with RF_Address=2 and RF_WrData=0x000B; Ack0 pulses two cycles after sampling; Ack1 stays 0.
- Single read: preload RF[2]=0x000B, then Req1, Wr1=0, Addr1=2 -> Ack1 at N+3 with RData1=0x000B; RData0 unchanged.
- Tie round-robin: Req0 and Req1 both held high, both writes -> grants go 0,1,0,1. With REGFILE_ARB_FIXED_PRIO_EN defined -> grants go 0,0,0.
- Out-of-range: DEPTH=6, read of Addr=7 -> no RF_RdEn, Ack at N+3, RData=0. Write of Addr=6 -> no RF_WrEn, Ack at N+2.
- Reset mid-read: RST high during RDWAIT -> all outputs return to reset values at that edge, no Ack; the next Req0 read completes normally.
- Back-to-back: Req0 held for 4 writes to addresses 0..3, then reads of addresses 0..3 -> RData0 returns 0x000E, 0x000D, 0x000B, 0x0007; Ack spacing is 3 cycles for writes and 4 for reads.
